// File: rtl/uart_tx_byte_fifo_if.sv
// Transmit FIFO port bundle: bus-side write strobe, transmitter-side
// read strobe, and the status and overflow signals.
interface uart_tx_byte_fifo_if #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
);
    logic                  fifo_write_n;
    logic [WIDTH-1:0]      fifo_din;
    logic                  fifo_read_n;
    logic [WIDTH-1:0]      fifo_dout;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [DEPTH_LOG2:0]   fifo_count;
    logic                  fifo_ovf;
    logic                  fifo_ovf_clr;

    modport master (
        output fifo_write_n,
        output fifo_din,
        output fifo_read_n,
        output fifo_ovf_clr,
        input  fifo_dout,
        input  fifo_empty,
        input  fifo_full,
        input  fifo_count,
        input  fifo_ovf
    );

    modport slave (
        input  fifo_write_n,
        input  fifo_din,
        input  fifo_read_n,
        input  fifo_ovf_clr,
        output fifo_dout,
        output fifo_empty,
        output fifo_full,
        output fifo_count,
        output fifo_ovf
    );
endinterface

// File: rtl/uart_tx_byte_fifo.sv
// Synchronous byte FIFO for the UART transmit path, 1-clk read latency.
// Sticky overflow flag enabled by defining TX_FIFO_OVF_FLAG_EN.
module uart_tx_byte_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    uart_tx_byte_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic [WIDTH-1:0]    r_dout;

    logic                w_empty;
    logic                w_full;
    logic                w_wr_acc;
    logic                w_rd_acc;
    logic                w_ovf_evt;
    logic [DEPTH_LOG2-1:0] w_wr_idx;
    logic [DEPTH_LOG2-1:0] w_rd_idx;

    assign w_wr_idx = r_wr_ptr[DEPTH_LOG2-1:0];
    assign w_rd_idx = r_rd_ptr[DEPTH_LOG2-1:0];

    // Flags come straight from the registered pointers; the MSB is the wrap bit.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (w_wr_idx == w_rd_idx) &&
                     (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]);

    assign w_wr_acc  = !bus.fifo_write_n && !w_full;
    assign w_rd_acc  = !bus.fifo_read_n  && !w_empty;
    assign w_ovf_evt = !bus.fifo_write_n &&  w_full;

    // Storage array; not reset, stale contents are unreachable after reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[w_wr_idx] <= bus.fifo_din;
        end
    end

    // Write pointer advances on each accepted byte, wrapping modulo 2*DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
        end else if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
        end
    end

    // Read pointer and registered output data; dout holds between reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_dout   <= '0;
        end else if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_dout   <= r_mem[w_rd_idx];
        end
    end

    assign bus.fifo_dout  = r_dout;
    assign bus.fifo_empty = w_empty;
    assign bus.fifo_full  = w_full;
    assign bus.fifo_count = r_wr_ptr - r_rd_ptr;

`ifdef TX_FIFO_OVF_FLAG_EN
    logic r_ovf;

    // Sticky overflow: a drop on the same edge as a clear keeps it set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_evt) begin
            r_ovf <= 1'b1;
        end else if (bus.fifo_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign bus.fifo_ovf = r_ovf;
`else
    logic w_unused_ovf;

    assign w_unused_ovf = w_ovf_evt ^ bus.fifo_ovf_clr;
    assign bus.fifo_ovf = 1'b0;
`endif
endmodule
